evm_ballot_ctrl: RTL and testbench
==================================

// Module: evm_ballot_ctrl
// PURPOSE
//   Parametrised electronic voting machine core with N candidate channels and an optional NOTA channel.
//   A presiding-officer handshake arms exactly one ballot per voter. Counters saturate at full scale.
//   Vote totals, the winner and a tie flag are produced as registered outputs.
//   Sits between the debounced voter-switch/officer-panel front end and the result display/readout logic.
// PARAMETERS
//   N_CAND   5  number of vote channels (>=2); channel N_CAND-1 is NOTA when NOTA_EN=1
//   NOTA_EN  1  1: top channel counted but excluded from winner/tie; 0: all channels are candidates
//   CNT_W    8  width of each per-channel vote counter
//   LED_HOLD 2  cycles the per-channel confirmation LED stays lit after an accepted vote (>=1)
//   (derived) WIN_W = $clog2(N_CAND+1); TOT_W = CNT_W + $clog2(N_CAND)
// PORTS
//   clk         in   1               system clock, rising edge
//   rst         in   1               asynchronous reset, active-high
//   ballot_open in   1               officer pulse/level: arm one ballot (honoured in IDLE only)
//   vo_switch   in   N_CAND          voter switches, bit i = channel i
//   close_poll  in   1               end polling; freeze counts
//   clear       in   1               sync clear of all counts; honoured in IDLE/CLOSED only
//   ready       out  1               1 in ARMED: voter may press
//   vote_ack    out  1               1-cycle pulse: vote accepted
//   invalid     out  1               1-cycle pulse: multi-hot press or press on saturated channel
//   overflow    out  1               sticky: a vote was refused by saturation; cleared by rst/clear
//   counts      out  N_CAND*CNT_W    flat counter bus, channel i at [i*CNT_W +: CNT_W]
//   total       out  TOT_W           sum of all channel counts
//   winner      out  WIN_W           1-based index of strict-max candidate; 0 = none/tie/no votes
//   tie         out  1               1 when >=2 candidates share a non-zero maximum
//   pled        out  N_CAND          per-channel confirmation LEDs
//   poll_closed out  1               1 in CLOSED
// BEHAVIOUR
//   Reset: state=IDLE; all counts, total, winner, tie, pled, LED timers, ready, vote_ack, invalid,
//   overflow and poll_closed are 0. Reset mid-ballot discards the pending ballot.
//   FSM states: IDLE, ARMED, CLOSED. close_poll has priority over every other transition.
//   - IDLE: ballot_open=1 -> ARMED. close_poll=1 -> CLOSED. clear=1 -> all counts and overflow are 0 next cycle.
//   - ARMED: ready=1. vo_switch is sampled every cycle:
//       all-zero -> stay ARMED;
//       one-hot at bit i, count[i] < max -> count[i]+1, vote_ack=1, pled[i]=1, timer[i]=LED_HOLD,
//         all on the next edge; state -> IDLE;
//       one-hot at bit i, count[i] at all-ones -> no increment, invalid=1, overflow=1, stay ARMED;
//       multi-hot -> invalid=1, no count change, stay ARMED.
//     ballot_open and clear are ignored in ARMED, so at most one vote is taken per arm.
//   - CLOSED: counts frozen; vo_switch and ballot_open are ignored; clear zeroes counts but the state
//     stays CLOSED. Only rst leaves CLOSED.
//   LEDs: while timer[i] is non-zero it decrements each cycle and pled[i]=1. pled[i] goes 0 when the timer
//     reaches 0, so an accepted vote lights pled[i] for exactly LED_HOLD cycles. A new vote on the same
//     channel reloads the timer. LEDs keep counting down in CLOSED.
//   Results: total, winner and tie are registered from the counts, 1 cycle after the count update
//     (vote_ack is at cycle t, results change at t+1).
//     Only candidate channels are compared (NOTA excluded when NOTA_EN=1).
//     All-zero candidates -> winner=0, tie=0.
//     total is computed at full TOT_W width and never wraps.
// TESTING
//   1) rst=1 then 0; ballot_open; vo_switch=5'b00100 -> vote_ack at next edge, counts[2]=1, pled[2] high
//      2 cycles, state IDLE, winner=3 one cycle later.
//   2) ARMED, vo_switch=5'b00110 -> invalid pulse, counts unchanged, ready stays 1;
//      then 5'b00001 -> counts[0]=1, vote_ack.
//   3) One arm, vo_switch=5'b00001 held for 4 cycles -> exactly one increment.
//      ballot_open asserted in ARMED does not cause a second vote.
//   4) 2 votes ch0, 2 votes ch1, 3 votes ch4 (NOTA) -> winner=0, tie=1, total=7;
//      with NOTA_EN=0 -> winner=5, tie=0.
//   5) CNT_W=2: 3 votes ch1, then 4th arm + press ch1 -> counts[1]=3, invalid=1, overflow=1, ready stays 1.
//   6) close_poll during ARMED with press on the same cycle -> CLOSED, no increment.
//      Later presses are ignored. clear -> counts 0, poll_closed stays 1. rst asserted mid-ballot -> all outputs 0.

Source files
------------

// File: rtl/evm_ballot_ctrl.sv
// Electronic voting machine core: one ballot per officer arm, saturating per-channel
// counters, confirmation LEDs and registered total/winner/tie results.
module evm_ballot_ctrl #(
  parameter int N_CAND   = 5,
  parameter int NOTA_EN  = 1,
  parameter int CNT_W    = 8,
  parameter int LED_HOLD = 2,
  localparam int WIN_W   = $clog2(N_CAND + 1),
  localparam int TOT_W   = CNT_W + $clog2(N_CAND)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ballot_open,
  input  logic [N_CAND-1:0]         vo_switch,
  input  logic                      close_poll,
  input  logic                      clear,
  output logic                      ready,
  output logic                      vote_ack,
  output logic                      invalid,
  output logic                      overflow,
  output logic [N_CAND*CNT_W-1:0]   counts,
  output logic [TOT_W-1:0]          total,
  output logic [WIN_W-1:0]          winner,
  output logic                      tie,
  output logic [N_CAND-1:0]         pled,
  output logic                      poll_closed
);

  localparam int IDX_W  = $clog2(N_CAND);
  localparam int TMR_W  = $clog2(LED_HOLD + 1);
  localparam int N_RANK = (NOTA_EN != 0) ? N_CAND - 1 : N_CAND;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_CLOSED = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [N_CAND-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CAND-1:0][TMR_W-1:0]    tmr_q, tmr_d;
  logic [N_CAND-1:0]               pled_q, pled_d;
  logic [N_CAND-1:0]               load_s;
  logic                            ready_q, ready_d;
  logic                            ack_q, ack_d;
  logic                            inv_q, inv_d;
  logic                            ovf_q, ovf_d;
  logic                            closed_q, closed_d;
  logic [TOT_W-1:0]                total_q, total_d;
  logic [WIN_W-1:0]                winner_q, winner_d;
  logic                            tie_q, tie_d;
  logic [IDX_W-1:0]                sel_idx_s;
  logic                            sw_onehot_s;
  logic [CNT_W-1:0]                max_v_s;
  logic [WIN_W-1:0]                max_idx_s;
  logic                            multi_s;

  // Decode the voter switches: one-hot test and selected channel index.
  always_comb begin
    sw_onehot_s = (vo_switch != {N_CAND{1'b0}}) &&
                  ((vo_switch & (vo_switch - N_CAND'(1))) == {N_CAND{1'b0}});
    sel_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < N_CAND; i++) begin
      sel_idx_s = vo_switch[i] ? IDX_W'(i) : sel_idx_s;
    end
  end

  // Ballot FSM next state, counter updates and pulse outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ack_d   = 1'b0;
    inv_d   = 1'b0;
    load_s  = {N_CAND{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (close_poll) begin
          state_d = S_CLOSED;
        end else if (ballot_open) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
        if (clear) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ARMED: begin
        if (close_poll) begin
          state_d = S_CLOSED;
        end else if (sw_onehot_s) begin
          if (cnt_q[sel_idx_s] != {CNT_W{1'b1}}) begin
            cnt_d[sel_idx_s]  = cnt_q[sel_idx_s] + CNT_W'(1);
            ack_d             = 1'b1;
            load_s[sel_idx_s] = 1'b1;
            state_d           = S_IDLE;
          end else begin
            // Saturated channel: refuse, flag, and keep the ballot open for another choice.
            inv_d = 1'b1;
            ovf_d = 1'b1;
          end
        end else if (vo_switch != {N_CAND{1'b0}}) begin
          inv_d = 1'b1;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CLOSED: begin
        state_d = S_CLOSED;
        if (clear) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d  = (state_d == S_ARMED);
    closed_d = (state_d == S_CLOSED);
  end

  // LED hold timers: reload on an accepted vote, otherwise count down to zero.
  always_comb begin
    tmr_d  = tmr_q;
    pled_d = {N_CAND{1'b0}};
    for (int i = 0; i < N_CAND; i++) begin
      if (load_s[i]) begin
        tmr_d[i] = TMR_W'(LED_HOLD);
      end else if (tmr_q[i] != {TMR_W{1'b0}}) begin
        tmr_d[i] = tmr_q[i] - TMR_W'(1);
      end else begin
        tmr_d[i] = tmr_q[i];
      end
      pled_d[i] = (tmr_d[i] != {TMR_W{1'b0}});
    end
  end

  // Results from the current counts; NOTA is summed but never ranked.
  always_comb begin
    total_d   = {TOT_W{1'b0}};
    max_v_s   = {CNT_W{1'b0}};
    max_idx_s = {WIN_W{1'b0}};
    multi_s   = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      total_d = total_d + TOT_W'(cnt_q[i]);
    end
    for (int i = 0; i < N_RANK; i++) begin
      if (cnt_q[i] > max_v_s) begin
        max_v_s   = cnt_q[i];
        max_idx_s = WIN_W'(i + 1);
        multi_s   = 1'b0;
      end else if (cnt_q[i] == max_v_s) begin
        multi_s = 1'b1;
      end else begin
        multi_s = multi_s;
      end
    end
    if ((max_v_s != {CNT_W{1'b0}}) && !multi_s) begin
      winner_d = max_idx_s;
    end else begin
      winner_d = {WIN_W{1'b0}};
    end
    tie_d = (max_v_s != {CNT_W{1'b0}}) && multi_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      pled_q   <= {N_CAND{1'b0}};
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      closed_q <= 1'b0;
      total_q  <= {TOT_W{1'b0}};
      winner_q <= {WIN_W{1'b0}};
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      pled_q   <= pled_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
      closed_q <= closed_d;
      total_q  <= total_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  assign ready       = ready_q;
  assign vote_ack    = ack_q;
  assign invalid     = inv_q;
  assign overflow    = ovf_q;
  assign counts      = cnt_q;
  assign total       = total_q;
  assign winner      = winner_q;
  assign tie         = tie_q;
  assign pled        = pled_q;
  assign poll_closed = closed_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Scoreboard bench for evm_ballot_ctrl: instance a uses defaults (NOTA on, 8-bit counts),
// instance b uses NOTA_EN=0 and 2-bit counts; both see identical stimulus.
module tb_evm_ballot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ballot_open = 1'b0;
  logic [4:0]  vo_switch = 5'b00000;
  logic        close_poll = 1'b0;
  logic        clear = 1'b0;

  logic        ready_a, ack_a, inv_a, ovf_a, closed_a, tie_a;
  logic [39:0] counts_a;
  logic [10:0] total_a;
  logic [2:0]  winner_a;
  logic [4:0]  pled_a;

  logic        ready_b, ack_b, inv_b, ovf_b, closed_b, tie_b;
  logic [9:0]  counts_b;
  logic [4:0]  total_b;
  logic [2:0]  winner_b;
  logic [4:0]  pled_b;

  always #5 clk = ~clk;

  evm_ballot_ctrl #(.N_CAND(5), .NOTA_EN(1), .CNT_W(8), .LED_HOLD(2)) dut_a (
    .clk(clk), .rst(rst), .ballot_open(ballot_open), .vo_switch(vo_switch),
    .close_poll(close_poll), .clear(clear), .ready(ready_a), .vote_ack(ack_a),
    .invalid(inv_a), .overflow(ovf_a), .counts(counts_a), .total(total_a),
    .winner(winner_a), .tie(tie_a), .pled(pled_a), .poll_closed(closed_a)
  );

  evm_ballot_ctrl #(.N_CAND(5), .NOTA_EN(0), .CNT_W(2), .LED_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .ballot_open(ballot_open), .vo_switch(vo_switch),
    .close_poll(close_poll), .clear(clear), .ready(ready_b), .vote_ack(ack_b),
    .invalid(inv_b), .overflow(ovf_b), .counts(counts_b), .total(total_b),
    .winner(winner_b), .tie(tie_b), .pled(pled_b), .poll_closed(closed_b)
  );

  typedef struct {
    int          k;
    int          ready, ack, inv, ovf, closed, pled, total, winner, tie;
    logic [39:0] cnts;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state per instance (0 = a, 1 = b); states 0 idle, 1 armed, 2 closed.
  int m_st[2];
  int m_cnt[2][5];
  int m_tmr[2][5];
  int m_ovf[2];
  int m_max[2]  = '{255, 3};
  int m_nota[2] = '{1, 0};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_ovf[k] = 0;
      for (int i = 0; i < 5; i++) begin
        m_cnt[k][i] = 0; m_tmr[k][i] = 0;
      end
      e = '{k: k, ready: 0, ack: 0, inv: 0, ovf: 0, closed: 0, pled: 0,
            total: 0, winner: 0, tie: 0, cnts: 40'd0};
      sbq.push_back(e);
    end
  endtask

  task automatic model_step(input int k, input logic bo, input logic [4:0] sw,
                            input logic cp, input logic cl);
    exp_t e;
    int tot, mx, nwin, widx, ncand, sel;
    tot = 0;
    for (int i = 0; i < 5; i++) tot += m_cnt[k][i];
    ncand = (m_nota[k] != 0) ? 4 : 5;
    mx = 0;
    for (int i = 0; i < ncand; i++) if (m_cnt[k][i] > mx) mx = m_cnt[k][i];
    nwin = 0; widx = 0;
    for (int i = 0; i < ncand; i++) begin
      if (mx > 0 && m_cnt[k][i] == mx) begin
        nwin++; widx = i + 1;
      end
    end
    e.k = k; e.total = tot; e.winner = (nwin == 1) ? widx : 0; e.tie = (nwin >= 2) ? 1 : 0;
    e.ack = 0; e.inv = 0;
    for (int i = 0; i < 5; i++) if (m_tmr[k][i] > 0) m_tmr[k][i]--;
    sel = 0;
    for (int i = 0; i < 5; i++) if (sw[i]) sel = i;
    case (m_st[k])
      0: begin
        if (cp) m_st[k] = 2;
        else if (bo) m_st[k] = 1;
        if (cl) begin
          for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
          m_ovf[k] = 0;
        end
      end
      1: begin
        if (cp) m_st[k] = 2;
        else if ($countones(sw) == 1) begin
          if (m_cnt[k][sel] < m_max[k]) begin
            m_cnt[k][sel]++; e.ack = 1; m_tmr[k][sel] = 2; m_st[k] = 0;
          end else begin
            e.inv = 1; m_ovf[k] = 1;
          end
        end else if (sw != 5'b00000) e.inv = 1;
      end
      default: begin
        if (cl) begin
          for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
          m_ovf[k] = 0;
        end
      end
    endcase
    e.pled = 0;
    e.cnts = 40'd0;
    for (int i = 0; i < 5; i++) begin
      if (m_tmr[k][i] > 0) e.pled |= (1 << i);
      e.cnts[i*8 +: 8] = 8'(m_cnt[k][i]);
    end
    e.ready = (m_st[k] == 1) ? 1 : 0;
    e.closed = (m_st[k] == 2) ? 1 : 0;
    e.ovf = m_ovf[k];
    sbq.push_back(e);
  endtask

  task automatic compare_one();
    exp_t  e;
    string p;
    int    c;
    if (sbq.size() == 0) begin
      check_eq("sb.empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    p = (e.k == 0) ? "a" : "b";
    check_eq({p, ".ready"},  (e.k == 0) ? int'(ready_a)  : int'(ready_b),  e.ready);
    check_eq({p, ".ack"},    (e.k == 0) ? int'(ack_a)    : int'(ack_b),    e.ack);
    check_eq({p, ".inv"},    (e.k == 0) ? int'(inv_a)    : int'(inv_b),    e.inv);
    check_eq({p, ".ovf"},    (e.k == 0) ? int'(ovf_a)    : int'(ovf_b),    e.ovf);
    check_eq({p, ".closed"}, (e.k == 0) ? int'(closed_a) : int'(closed_b), e.closed);
    check_eq({p, ".pled"},   (e.k == 0) ? int'(pled_a)   : int'(pled_b),   e.pled);
    check_eq({p, ".total"},  (e.k == 0) ? int'(total_a)  : int'(total_b),  e.total);
    check_eq({p, ".winner"}, (e.k == 0) ? int'(winner_a) : int'(winner_b), e.winner);
    check_eq({p, ".tie"},    (e.k == 0) ? int'(tie_a)    : int'(tie_b),    e.tie);
    for (int i = 0; i < 5; i++) begin
      c = (e.k == 0) ? int'(counts_a[i*8 +: 8]) : int'(counts_b[i*2 +: 2]);
      check_eq($sformatf("%s.cnt%0d", p, i), c, int'(e.cnts[i*8 +: 8]));
    end
  endtask

  task automatic step(input logic bo, input logic [4:0] sw, input logic cp, input logic cl);
    ballot_open = bo; vo_switch = sw; close_poll = cp; clear = cl;
    model_step(0, bo, sw, cp, cl);
    model_step(1, bo, sw, cp, cl);
    @(posedge clk);
    #1;
    compare_one();
    compare_one();
  endtask

  task automatic do_reset();
    ballot_open = 1'b0; vo_switch = 5'b00000; close_poll = 1'b0; clear = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    compare_one();
    compare_one();
    rst = 1'b0;
  endtask

  task automatic vote(input int ch);
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b00001 << ch, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'b00000, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    // basic vote, LED hold and delayed winner
    vote(2);
    idle(3);
    // multi-hot refused, then a valid vote
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b00110, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 1'b0, 1'b0);
    // held press and ballot_open in ARMED give a single vote
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00001, 1'b0, 1'b0);
    // clear ignored while armed, honoured in idle
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 1'b0, 1'b1);
    step(1'b0, 5'b01000, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 1'b0, 1'b1);
    idle(1);
    // tie with NOTA excluded (a) versus NOTA as candidate 5 (b)
    do_reset();
    vote(0); vote(0); vote(1); vote(1); vote(4); vote(4); vote(4);
    idle(1);
    check_eq("t4.a.winner", int'(winner_a), 0);
    check_eq("t4.a.tie", int'(tie_a), 1);
    check_eq("t4.a.total", int'(total_a), 7);
    check_eq("t4.b.winner", int'(winner_b), 5);
    check_eq("t4.b.tie", int'(tie_b), 0);
    // saturation on the 2-bit instance
    do_reset();
    vote(1); vote(1); vote(1);
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b00010, 1'b0, 1'b0);
    check_eq("t5.b.cnt1", int'(counts_b[3:2]), 3);
    check_eq("t5.b.inv", int'(inv_b), 1);
    check_eq("t5.b.ovf", int'(ovf_b), 1);
    check_eq("t5.b.ready", int'(ready_b), 1);
    idle(1);
    // close during armed press, ignored presses, clear in closed
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 1'b1, 1'b0);
    step(1'b1, 5'b00010, 1'b0, 1'b0);
    step(1'b0, 5'b00100, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 1'b0, 1'b1);
    idle(2);
    // reset mid-ballot, then normal operation resumes
    do_reset();
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    do_reset();
    vote(3);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
